mem_access_unit: RTL and testbench
==================================

Name: mem_access_unit

Overview:
MEM-stage engine that consumes the EX/MEM pipeline register outputs and runs the load/store over a req/ack data-memory bus with wait states. It formats load and store data by size, and detects misaligned accesses for the interrupt logic. It produces the MEM/WB pipeline register contents. It drives the stall that holds EX/MEM and the upstream stages while a bus access is outstanding.

Parameters:
TIMEOUT, 16, bus watchdog limit in cycles (used only with MEM_TIMEOUT_EN)

Ports:
clk  in  1  clock, all state on posedge
rst  in  1  synchronous reset, active-low
WB  in  5  WB control from EX/MEM, passed through
M  in  10  MEM control: [0] MemRead, [1] MemWrite, [3:2] size (00 word, 01 half, 10 byte, 11 reserved = word), [4] load sign-extend, [9:5] ignored
aluout  in  32  effective address / ALU result
rd2  in  32  store data
dst  in  5  destination register
pc  in  32  instruction PC
memwb_flush  in  1  clear MEM/WB output this edge
mem_stall  out  1  hold EX/MEM and earlier stages
dm_req  out  1  bus request
dm_we  out  1  bus write
dm_addr  out  32  word address {aluout[31:2],2'b00}
dm_wdata  out  32  lane-replicated store data
dm_be  out  4  byte enables
dm_ack  in  1  bus completion, one cycle
dm_rdata  in  32  read data, valid with dm_ack
OWB  out  5  registered WB
Ordata  out  32  formatted load data
Oaluout  out  32  registered aluout
Odst  out  5  registered dst
Opc  out  32  registered pc
Oexc  out  2  00 none, 01 AdEL, 10 AdES, 11 bus error
Obadaddr  out  32  faulting address

Behaviour:
- Reset (rst=0 at posedge): state IDLE, all registered outputs 0, dm_req=0, dm_we=0, dm_be=0. Reset aborts any access in progress; a late dm_ack is ignored.
- memop = M[0]|M[1]; if both are set, treat as a store.
- Misalignment: half with aluout[0]=1, or word with aluout[1:0]!=0.
- A misaligned memop makes no bus access and asserts no stall. MEM/WB loads on the next edge with Oexc=01 (load) or 10 (store), Obadaddr=aluout, and OWB forced to 0 to suppress writeback.
- FSM states are IDLE, WAIT and DONE.
  - IDLE with an aligned memop: go to WAIT and latch addr, we, be and wdata. mem_stall=1 combinationally.
  - IDLE with a non-memop: MEM/WB loads each edge with no stall. Ordata=0 and Oexc=00.
  - WAIT: dm_req=1, mem_stall=1. On dm_ack, capture formatted rdata and go to DONE. The same-cycle ack is accepted.
  - DONE: dm_req=0, mem_stall=0. MEM/WB loads at this edge, using the captured data for loads and 0 for stores. Then go to IDLE.
- Minimum memop latency is 3 cycles, with one stall cycle beyond the ack cycle. dm_req drops the cycle after dm_ack.
- Byte lanes are little-endian: lane k = bits [8k+7:8k] at addr[1:0]=k.
- Byte access: dm_be=1<<addr[1:0]; wdata = rd2[7:0] replicated to all 4 lanes.
- Half access: dm_be = addr[1] ? 1100 : 0011; wdata = rd2[15:0] replicated.
- Word access: dm_be=1111.
- Load data is extracted from the selected lane, then zero- or sign-extended per M[4].
- memwb_flush=1 zeroes all MEM/WB outputs at that edge and has priority over any load. The FSM is unaffected: an outstanding access still completes (stores commit), and its DONE result is lost only if a flush coincides with the DONE edge.
- dm_ack is ignored outside WAIT.

Optional Feature:
MEM_TIMEOUT_EN
- Defined: a counter clears on entry to WAIT and increments each WAIT cycle. When it reaches TIMEOUT-1 without an ack, go to DONE with Oexc=11, Obadaddr=address, OWB=0 and Ordata=0.
- Not defined: WAIT holds indefinitely until dm_ack; no counter logic exists.

Test Plan:
- Load byte signed, aluout=0x103, M=0x019, dm_rdata=0x80AB_CDEF, ack after 2 WAIT cycles -> dm_be=1000, mem_stall high 3 cycles, Ordata=0xFFFF_FF80, Oexc=00.
- Store half, aluout=0x202, rd2=0x1234_5678, M=0x006, immediate ack -> dm_we=1, dm_be=1100, dm_wdata=0x5678_5678, dm_addr=0x200, stall exactly 2 cycles.
- Load word at aluout=0x0000_0006 -> no dm_req, no stall, Oexc=01, Obadaddr=0x6, OWB=0.
- Non-memop stream (M=0) for 5 cycles -> MEM/WB follows inputs with 1-cycle latency, mem_stall never high.
- rst low during WAIT, then ack arrives -> state IDLE, all outputs 0, late ack ignored; memwb_flush at the DONE edge -> outputs 0.
- With MEM_TIMEOUT_EN and TIMEOUT=4, load with no ack -> after 4 WAIT cycles Oexc=11, Obadaddr=address, stall released.

Source files
------------

// File: rtl/mem_access_unit.sv
// MEM-stage load/store engine: runs one access at a time over a req/ack data bus and
// produces the MEM/WB register. Optional bus watchdog enabled by defining MEM_TIMEOUT_EN.
module mem_access_unit #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  WB,
    input  logic [9:0]  M,
    input  logic [31:0] aluout,
    input  logic [31:0] rd2,
    input  logic [4:0]  dst,
    input  logic [31:0] pc,
    input  logic        memwb_flush,
    output logic        mem_stall,
    output logic        dm_req,
    output logic        dm_we,
    output logic [31:0] dm_addr,
    output logic [31:0] dm_wdata,
    output logic [3:0]  dm_be,
    input  logic        dm_ack,
    input  logic [31:0] dm_rdata,
    output logic [4:0]  OWB,
    output logic [31:0] Ordata,
    output logic [31:0] Oaluout,
    output logic [4:0]  Odst,
    output logic [31:0] Opc,
    output logic [1:0]  Oexc,
    output logic [31:0] Obadaddr
);

    typedef enum logic [1:0] {StIdle, StWait, StDone} state_e;

    state_e      state_q, state_d;
    logic        memop, is_store, is_byte, is_half, misaligned, start;
    logic [3:0]  be_d;
    logic [31:0] wdata_d;

    logic [31:0] addr_q, wdata_q, rdata_q;
    logic [3:0]  be_q;
    logic        we_q, byte_q, half_q, sext_q;
    logic        timeout_fire, tout_q;

    logic        mw_load;
    logic [4:0]  owb_d;
    logic [31:0] ordata_d, bad_d;
    logic [1:0]  exc_d;

    logic        unused_m;
    assign unused_m = ^M[9:5];

    function automatic logic [31:0] fmt_load(input logic [31:0] data, input logic [1:0] lane,
                                             input logic byte_op, input logic half_op,
                                             input logic sext);
        logic [31:0] sh;
        sh = data >> {lane, 3'b000};
        if (byte_op) begin
            fmt_load = {{24{sext & sh[7]}}, sh[7:0]};
        end else if (half_op) begin
            fmt_load = {{16{sext & sh[15]}}, sh[15:0]};
        end else begin
            fmt_load = data;
        end
    endfunction

    always_comb begin
        memop      = M[0] | M[1];
        is_store   = M[1];
        is_byte    = (M[3:2] == 2'b10);
        is_half    = (M[3:2] == 2'b01);
        misaligned = is_half ? aluout[0] : (!is_byte && (aluout[1:0] != 2'b00));
        start      = (state_q == StIdle) && memop && !misaligned;
        if (is_byte) begin
            be_d    = 4'b0001 << aluout[1:0];
            wdata_d = {4{rd2[7:0]}};
        end else if (is_half) begin
            be_d    = aluout[1] ? 4'b1100 : 4'b0011;
            wdata_d = {2{rd2[15:0]}};
        end else begin
            be_d    = 4'b1111;
            wdata_d = rd2;
        end
    end

`ifdef MEM_TIMEOUT_EN
    logic [31:0] wait_cnt_q;

    assign timeout_fire = (state_q == StWait) && !dm_ack && (wait_cnt_q == TIMEOUT - 1);

    always_ff @(posedge clk) begin
        if (!rst) begin
            wait_cnt_q <= '0;
            tout_q     <= 1'b0;
        end else if (start) begin
            wait_cnt_q <= '0;
            tout_q     <= 1'b0;
        end else if (state_q == StWait) begin
            wait_cnt_q <= wait_cnt_q + 32'd1;
            if (timeout_fire) tout_q <= 1'b1;
        end
    end
`else
    // Watchdog absent: WAIT only ends on dm_ack.
    localparam int unsigned unused_timeout = TIMEOUT;
    assign timeout_fire = 1'b0;
    assign tout_q       = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:  if (start) state_d = StWait;
            StWait:  if (dm_ack || timeout_fire) state_d = StDone;
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    assign mem_stall = start || (state_q == StWait);
    assign dm_req    = (state_q == StWait);
    assign dm_we     = we_q;
    assign dm_be     = be_q;
    assign dm_wdata  = wdata_q;
    assign dm_addr   = {addr_q[31:2], 2'b00};

    always_comb begin
        mw_load  = 1'b0;
        owb_d    = WB;
        ordata_d = '0;
        exc_d    = 2'b00;
        bad_d    = '0;
        if (state_q == StIdle && !start) begin
            mw_load = 1'b1;
            // A memop that did not start is misaligned: trap and suppress writeback.
            if (memop) begin
                owb_d = '0;
                exc_d = is_store ? 2'b10 : 2'b01;
                bad_d = aluout;
            end
        end else if (state_q == StDone) begin
            mw_load = 1'b1;
            if (tout_q) begin
                owb_d = '0;
                exc_d = 2'b11;
                bad_d = addr_q;
            end else if (!we_q) begin
                ordata_d = rdata_q;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q  <= StIdle;
            addr_q   <= '0;
            we_q     <= 1'b0;
            be_q     <= '0;
            wdata_q  <= '0;
            byte_q   <= 1'b0;
            half_q   <= 1'b0;
            sext_q   <= 1'b0;
            rdata_q  <= '0;
            OWB      <= '0;
            Ordata   <= '0;
            Oaluout  <= '0;
            Odst     <= '0;
            Opc      <= '0;
            Oexc     <= '0;
            Obadaddr <= '0;
        end else begin
            state_q <= state_d;
            if (start) begin
                addr_q  <= aluout;
                we_q    <= is_store;
                be_q    <= be_d;
                wdata_q <= wdata_d;
                byte_q  <= is_byte;
                half_q  <= is_half;
                sext_q  <= M[4];
            end
            if (state_q == StWait && dm_ack) begin
                rdata_q <= fmt_load(dm_rdata, addr_q[1:0], byte_q, half_q, sext_q);
            end
            if (memwb_flush) begin
                OWB      <= '0;
                Ordata   <= '0;
                Oaluout  <= '0;
                Odst     <= '0;
                Opc      <= '0;
                Oexc     <= '0;
                Obadaddr <= '0;
            end else if (mw_load) begin
                OWB      <= owb_d;
                Ordata   <= ordata_d;
                Oaluout  <= aluout;
                Odst     <= dst;
                Opc      <= pc;
                Oexc     <= exc_d;
                Obadaddr <= bad_d;
            end
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Table-driven bench for mem_access_unit: single-cycle vectors, bus access vectors, and
// hand sequences for reset, flush and (with MEM_TIMEOUT_EN) the watchdog.
`timescale 1ns/1ps
module tb_mem_access_unit;

`ifdef MEM_TIMEOUT_EN
    localparam int unsigned TO = 4;
`else
    localparam int unsigned TO = 16;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [4:0]  WB = '0;
    logic [9:0]  M = '0;
    logic [31:0] aluout = '0, rd2 = '0, pc = '0;
    logic [4:0]  dst = '0;
    logic        memwb_flush = 1'b0;
    logic        mem_stall, dm_req, dm_we;
    logic [31:0] dm_addr, dm_wdata;
    logic [3:0]  dm_be;
    logic        dm_ack = 1'b0;
    logic [31:0] dm_rdata = '0;
    logic [4:0]  OWB, Odst;
    logic [31:0] Ordata, Oaluout, Opc, Obadaddr;
    logic [1:0]  Oexc;

    int n_checks = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    mem_access_unit #(.TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .WB(WB), .M(M), .aluout(aluout), .rd2(rd2), .dst(dst), .pc(pc),
        .memwb_flush(memwb_flush), .mem_stall(mem_stall), .dm_req(dm_req), .dm_we(dm_we),
        .dm_addr(dm_addr), .dm_wdata(dm_wdata), .dm_be(dm_be), .dm_ack(dm_ack),
        .dm_rdata(dm_rdata), .OWB(OWB), .Ordata(Ordata), .Oaluout(Oaluout), .Odst(Odst),
        .Opc(Opc), .Oexc(Oexc), .Obadaddr(Obadaddr)
    );

    typedef struct {
        logic [4:0]  wb;
        logic [9:0]  m;
        logic [31:0] alu;
        logic [4:0]  dstv;
        logic [31:0] pcv;
        logic        flush;
        logic [4:0]  e_owb;
        logic [1:0]  e_exc;
        logic [31:0] e_bad;
    } sc_vec_t;

    typedef struct {
        logic [4:0]  wb;
        logic [9:0]  m;
        logic [31:0] alu;
        logic [31:0] rd2v;
        logic [31:0] rdata;
        int          ack_at;
        logic [31:0] e_addr;
        logic [3:0]  e_be;
        logic        e_we;
        logic [31:0] e_wdata;
        logic [31:0] e_ordata;
        int          e_stalls;
    } acc_vec_t;

    sc_vec_t  sc[11];
    acc_vec_t av[9];

    logic [31:0] seen_addr, seen_wdata;
    logic [3:0]  seen_be;
    logic        seen_we;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Runs one aligned access starting in the current (IDLE) cycle; returns at the negedge
    // after the DONE edge. flush_mode: 0 none, 1 flush in first WAIT cycle, 2 flush in DONE.
    task automatic do_access(input int ack_at, input logic [31:0] rdata, input int flush_mode,
                             output int stalls, output int reqs, output bit ok);
        int w;
        w = 0; stalls = 0; reqs = 0; ok = 1'b0;
        for (int c = 0; c < 40; c++) begin
            #1;
            if (mem_stall) stalls++;
            if (dm_req) begin
                if (w == 0) begin
                    seen_addr = dm_addr; seen_wdata = dm_wdata; seen_be = dm_be; seen_we = dm_we;
                    if (flush_mode == 1) memwb_flush = 1'b1;
                end
                reqs++;
                if (w == ack_at) begin
                    dm_ack = 1'b1;
                    dm_rdata = rdata;
                end
                w++;
            end else if (c > 0) begin
                if (flush_mode == 2) memwb_flush = 1'b1;
                ok = 1'b1;
            end
            @(negedge clk);
            dm_ack = 1'b0;
            dm_rdata = ~rdata;
            memwb_flush = 1'b0;
            if (ok) break;
        end
    endtask

    task automatic check_zero_outputs(input string tag);
        chk({tag, "_owb"}, OWB, 0);
        chk({tag, "_ordata"}, Ordata, 0);
        chk({tag, "_oaluout"}, Oaluout, 0);
        chk({tag, "_odst"}, Odst, 0);
        chk({tag, "_opc"}, Opc, 0);
        chk({tag, "_oexc"}, Oexc, 0);
        chk({tag, "_obad"}, Obadaddr, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        int stalls, reqs;
        bit ok;

        sc[0]  = '{5'h1F, 10'h000, 32'h1111_1111, 5'd3,  32'h100, 1'b0, 5'h1F, 2'b00, 32'h0};
        sc[1]  = '{5'h0A, 10'h3E0, 32'hCAFE_0003, 5'd9,  32'h104, 1'b0, 5'h0A, 2'b00, 32'h0};
        sc[2]  = '{5'h05, 10'h01C, 32'h0000_0007, 5'd1,  32'h108, 1'b0, 5'h05, 2'b00, 32'h0};
        sc[3]  = '{5'h13, 10'h000, 32'h0000_0055, 5'd4,  32'h10C, 1'b1, 5'h00, 2'b00, 32'h0};
        sc[4]  = '{5'h11, 10'h000, 32'hFFFF_FFFC, 5'd31, 32'h110, 1'b0, 5'h11, 2'b00, 32'h0};
        sc[5]  = '{5'h1F, 10'h001, 32'h0000_0006, 5'd2,  32'h114, 1'b0, 5'h00, 2'b01, 32'h6};
        sc[6]  = '{5'h1E, 10'h002, 32'h0000_0009, 5'd6,  32'h118, 1'b0, 5'h00, 2'b10, 32'h9};
        sc[7]  = '{5'h1D, 10'h005, 32'h0000_0101, 5'd7,  32'h11C, 1'b0, 5'h00, 2'b01, 32'h101};
        sc[8]  = '{5'h1C, 10'h007, 32'h0000_0003, 5'd8,  32'h120, 1'b0, 5'h00, 2'b10, 32'h3};
        sc[9]  = '{5'h1B, 10'h00D, 32'h0000_0002, 5'd10, 32'h124, 1'b0, 5'h00, 2'b01, 32'h2};
        sc[10] = '{5'h1A, 10'h001, 32'h0000_0007, 5'd11, 32'h128, 1'b1, 5'h00, 2'b00, 32'h0};

        av[0] = '{5'h15, 10'h019, 32'h103,  32'h0,         32'h80AB_CDEF, 1, 32'h100,  4'b1000,
                  1'b0, 32'h0,         32'hFFFF_FF80, 3};
        av[1] = '{5'h0C, 10'h006, 32'h202,  32'h1234_5678, 32'hFFFF_FFFF, 0, 32'h200,  4'b1100,
                  1'b1, 32'h5678_5678, 32'h0,         2};
        av[2] = '{5'h01, 10'h005, 32'h102,  32'h0,         32'h9ABC_1234, 0, 32'h100,  4'b1100,
                  1'b0, 32'h0,         32'h0000_9ABC, 2};
        av[3] = '{5'h02, 10'h015, 32'h100,  32'h0,         32'h1234_F00D, 2, 32'h100,  4'b0011,
                  1'b0, 32'h0,         32'hFFFF_F00D, 4};
        av[4] = '{5'h03, 10'h00A, 32'h301,  32'hAABB_CCDD, 32'h0,         0, 32'h300,  4'b0010,
                  1'b1, 32'hDDDD_DDDD, 32'h0,         2};
        av[5] = '{5'h04, 10'h001, 32'h44,   32'h0,         32'hDEAD_BEEF, 3, 32'h44,   4'b1111,
                  1'b0, 32'h0,         32'hDEAD_BEEF, 5};
        av[6] = '{5'h06, 10'h009, 32'h1001, 32'h0,         32'h0000_8F00, 0, 32'h1000, 4'b0010,
                  1'b0, 32'h0,         32'h0000_008F, 2};
        av[7] = '{5'h07, 10'h003, 32'h20,   32'h0BAD_F00D, 32'h1111_2222, 0, 32'h20,   4'b1111,
                  1'b1, 32'h0BAD_F00D, 32'h0,         2};
        av[8] = '{5'h08, 10'h00D, 32'h8,    32'h0,         32'h7654_3210, 1, 32'h8,    4'b1111,
                  1'b0, 32'h0,         32'h7654_3210, 3};

        // Reset
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_req", dm_req, 0);
        chk("rst_we", dm_we, 0);
        chk("rst_be", dm_be, 0);
        check_zero_outputs("rst");
        rst = 1'b1;

        // Single-cycle vectors: non-memops, misaligned traps, flushes
        for (int i = 0; i < 11; i++) begin
            WB = sc[i].wb; M = sc[i].m; aluout = sc[i].alu; rd2 = 32'hA5A5_5A5A;
            dst = sc[i].dstv; pc = sc[i].pcv; memwb_flush = sc[i].flush;
            #1;
            chk($sformatf("sc%0d_stall", i), mem_stall, 0);
            chk($sformatf("sc%0d_req", i), dm_req, 0);
            @(negedge clk);
            memwb_flush = 1'b0;
            chk($sformatf("sc%0d_owb", i), OWB, sc[i].e_owb);
            chk($sformatf("sc%0d_oexc", i), Oexc, sc[i].e_exc);
            chk($sformatf("sc%0d_obad", i), Obadaddr, sc[i].e_bad);
            chk($sformatf("sc%0d_ordata", i), Ordata, 0);
            chk($sformatf("sc%0d_oaluout", i), Oaluout, sc[i].flush ? 32'h0 : sc[i].alu);
            chk($sformatf("sc%0d_odst", i), Odst, sc[i].flush ? 5'h0 : sc[i].dstv);
            chk($sformatf("sc%0d_opc", i), Opc, sc[i].flush ? 32'h0 : sc[i].pcv);
        end

        // Bus access vectors
        for (int i = 0; i < 9; i++) begin
            WB = av[i].wb; M = av[i].m; aluout = av[i].alu; rd2 = av[i].rd2v;
            dst = 5'(i + 1); pc = 32'h800 + 32'(4 * i);
            do_access(av[i].ack_at, av[i].rdata, 0, stalls, reqs, ok);
            chk($sformatf("av%0d_done", i), 32'(ok), 1);
            chk($sformatf("av%0d_stalls", i), stalls, av[i].e_stalls);
            chk($sformatf("av%0d_reqs", i), reqs, av[i].e_stalls - 1);
            chk($sformatf("av%0d_addr", i), seen_addr, av[i].e_addr);
            chk($sformatf("av%0d_be", i), seen_be, av[i].e_be);
            chk($sformatf("av%0d_we", i), seen_we, av[i].e_we);
            if (av[i].e_we) chk($sformatf("av%0d_wdata", i), seen_wdata, av[i].e_wdata);
            chk($sformatf("av%0d_ordata", i), Ordata, av[i].e_ordata);
            chk($sformatf("av%0d_owb", i), OWB, av[i].wb);
            chk($sformatf("av%0d_oexc", i), Oexc, 0);
            chk($sformatf("av%0d_obad", i), Obadaddr, 0);
            chk($sformatf("av%0d_oaluout", i), Oaluout, av[i].alu);
            chk($sformatf("av%0d_odst", i), Odst, i + 1);
            chk($sformatf("av%0d_opc", i), Opc, 32'h800 + 32'(4 * i));
        end

        // Reset in WAIT, then a late ack
        WB = 5'h1E; M = 10'h002; aluout = 32'h10; rd2 = 32'h1; dst = 5'd5; pc = 32'h900;
        #1;
        chk("rw_stall_idle", mem_stall, 1);
        @(negedge clk);
        chk("rw_req_wait", dm_req, 1);
        chk("rw_we_wait", dm_we, 1);
        rst = 1'b0;
        @(negedge clk);
        chk("rw_req", dm_req, 0);
        chk("rw_we", dm_we, 0);
        chk("rw_be", dm_be, 0);
        check_zero_outputs("rw");
        rst = 1'b1; M = 10'h000; WB = '0; aluout = '0; dst = '0; pc = '0; dm_ack = 1'b1;
        #1;
        chk("late_ack_stall", mem_stall, 0);
        @(negedge clk);
        dm_ack = 1'b0;
        #1;
        chk("late_ack_req", dm_req, 0);
        chk("late_ack_stall2", mem_stall, 0);
        @(negedge clk);

        // Flush mid-access does not abort it
        WB = 5'h0F; M = 10'h001; aluout = 32'h60; dst = 5'd12; pc = 32'hA00;
        do_access(1, 32'h1357_9BDF, 1, stalls, reqs, ok);
        chk("fw_done", 32'(ok), 1);
        chk("fw_stalls", stalls, 3);
        chk("fw_ordata", Ordata, 32'h1357_9BDF);
        chk("fw_owb", OWB, 5'h0F);

        // Flush coinciding with DONE loses the result
        WB = 5'h0E; M = 10'h001; aluout = 32'h64; dst = 5'd13; pc = 32'hA04;
        do_access(0, 32'h2468_ACE0, 2, stalls, reqs, ok);
        chk("fd_done", 32'(ok), 1);
        check_zero_outputs("fd");

`ifdef MEM_TIMEOUT_EN
        // Watchdog: load with no ack
        WB = 5'h1F; M = 10'h001; aluout = 32'h50; dst = 5'd14; pc = 32'hB00;
        do_access(99, 32'h0, 0, stalls, reqs, ok);
        chk("to_done", 32'(ok), 1);
        chk("to_stalls", stalls, 5);
        chk("to_reqs", reqs, 4);
        chk("to_oexc", Oexc, 2'b11);
        chk("to_obad", Obadaddr, 32'h50);
        chk("to_owb", OWB, 0);
        chk("to_ordata", Ordata, 0);
`endif

        M = 10'h000;
        @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
